// File: rtl/apb_fifo_sync.sv
// APB3-controlled synchronous FIFO with a stream pop port, occupancy thresholds and a registered interrupt.
// The push side is fed by APB writes to WDATA; the pop side drains through m_valid/m_ready.
module apb_fifo_sync #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [7:0]    PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          full_out,
    output logic          empty_out,
    output logic [LW-1:0] level_out,
    output logic          irq
);

    localparam int AW = LW - 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] ae_th_reg;
    logic [LW-1:0] af_th_reg;
    logic [2:0]    irq_en_reg;
    logic          en_reg;
    logic          ovf_reg;
    logic          irq_reg;

    logic access;
    logic addr_ok;
    logic wr_ctrl;
    logic wr_wdata;
    logic wr_thresh;
    logic wr_irq_en;
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic push_req;
    logic push;
    logic pop;
    logic overflow;
    logic flush;
    logic clr_ovf;
    logic [31:0] rdata;
    logic unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    assign access    = PSEL & PENABLE;
    assign addr_ok   = (PADDR == 8'h00) | (PADDR == 8'h04) | (PADDR == 8'h08) |
                       (PADDR == 8'h10) | (PADDR == 8'h14);
    assign wr_ctrl   = access & PWRITE & (PADDR == 8'h00);
    assign wr_wdata  = access & PWRITE & (PADDR == 8'h08);
    assign wr_thresh = access & PWRITE & (PADDR == 8'h10);
    assign wr_irq_en = access & PWRITE & (PADDR == 8'h14);

    assign empty        = (level_reg == '0);
    assign full         = (level_reg == DEPTH_L);
    assign almost_full  = (level_reg >= af_th_reg);
    assign almost_empty = (level_reg <= ae_th_reg);

    // Push/pop decisions use start-of-cycle full/empty so a pop never frees room for a same-cycle push.
    assign push_req = wr_wdata & en_reg;
    assign push     = push_req & ~full;
    assign overflow = push_req & full;
    assign pop      = ~empty & m_ready;
    assign flush    = wr_ctrl & PWDATA[1];
    assign clr_ovf  = wr_ctrl & PWDATA[2];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ae_th_reg  <= LW'(1);
            af_th_reg  <= LW'(DEPTH - 1);
            irq_en_reg <= '0;
            en_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_reg <= PWDATA[0];
            end
            if (wr_thresh) begin
                ae_th_reg <= PWDATA[LW-1:0];
                af_th_reg <= PWDATA[16 +: LW];
            end
            if (wr_irq_en) begin
                irq_en_reg <= PWDATA[2:0];
            end
            if (overflow) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end
            irq_reg <= |(irq_en_reg & {almost_empty, almost_full, ovf_reg});
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                if (push && !pop) begin
                    level_reg <= level_reg + LW'(1);
                end else if (pop && !push) begin
                    level_reg <= level_reg - LW'(1);
                end
            end
        end
    end

    // Storage is deliberately left unreset; only occupancy state decides what is visible.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= PWDATA[DW-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (!PWRITE) begin
            case (PADDR)
                8'h00: rdata[0] = en_reg;
                8'h04: begin
                    rdata[4:0]     = {almost_empty, almost_full, ovf_reg, full, empty};
                    rdata[16 +: LW] = level_reg;
                end
                8'h10: begin
                    rdata[LW-1:0]   = ae_th_reg;
                    rdata[16 +: LW] = af_th_reg;
                end
                8'h14: rdata[2:0] = irq_en_reg;
                default: rdata = '0;
            endcase
        end
    end

    assign PRDATA    = rdata;
    assign PREADY    = 1'b1;
    assign PSLVERR   = access & ~addr_ok & ~PRESET;
    assign m_valid   = ~empty;
    assign m_data    = empty ? '0 : mem[rd_ptr_reg];
    assign full_out  = full;
    assign empty_out = empty;
    assign level_out = level_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_apb_fifo_sync.sv
// Self-checking bench for apb_fifo_sync: register table plus scoreboarded FIFO sequences.
module tb_apb_fifo_sync;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int NVEC  = 20;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [7:0]    PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          full_out;
    logic          empty_out;
    logic [LW-1:0] level_out;
    logic          irq;

    apb_fifo_sync #(.DW(DW), .DEPTH(DEPTH)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .full_out  (full_out),
        .empty_out (empty_out),
        .level_out (level_out),
        .irq       (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t          vecs [NVEC];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    logic          en_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer (setup + access); m_ready is raised only in the access cycle.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                       input logic mr, output logic [31:0] rd, output logic err);
        bit full0, pop_do, push_do, flush_do;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1; m_ready = mr;
        #1;
        rd  = PRDATA;
        err = PSLVERR;
        full0    = (sb.size() == DEPTH);
        pop_do   = mr && (sb.size() != 0);
        push_do  = wr && (addr == 8'h08) && en_m && !full0;
        flush_do = wr && (addr == 8'h00) && data[1];
        if (pop_do) check("pop_data", 32'(m_data), 32'(sb[0]));
        @(posedge PCLK);
        if (flush_do) begin
            sb.delete();
        end else begin
            if (pop_do) void'(sb.pop_front());
            if (push_do) sb.push_back(data[DW-1:0]);
        end
        if (wr && addr == 8'h00) en_m = data[0];
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; m_ready = 1'b0;
        #1;
        $display("apb %s addr=%02h wdata=%08h rdata=%08h err=%0d", wr ? "W" : "R", addr, data, rd, err);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            m_ready = 1'b1;
            #1;
            check("drain_valid", 32'(m_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) check("drain_data", 32'(m_data), 32'(sb[0]));
            @(posedge PCLK);
            if (sb.size() != 0) void'(sb.pop_front());
            $display("pop cycle %0d remaining=%0d", i, sb.size());
        end
        @(negedge PCLK);
        m_ready = 1'b0;
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, 32'(level_out), 32'(sb.size()));
        check({tag, "_empty"}, 32'(empty_out), 32'(sb.size() == 0));
        check({tag, "_full"},  32'(full_out),  32'(sb.size() == DEPTH));
        check({tag, "_valid"}, 32'(m_valid),   32'(sb.size() != 0));
        if (sb.size() != 0) check({tag, "_head"}, 32'(m_data), 32'(sb[0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;

        vecs[0]  = '{1'b0, 8'h00, 32'h0,        32'h0000_0000, 1'b0, "ctrl_rst"};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,        32'h0000_0011, 1'b0, "status_rst"};
        vecs[2]  = '{1'b0, 8'h10, 32'h0,        32'h0007_0001, 1'b0, "thresh_rst"};
        vecs[3]  = '{1'b0, 8'h14, 32'h0,        32'h0000_0000, 1'b0, "irqen_rst"};
        vecs[4]  = '{1'b0, 8'h0C, 32'h0,        32'h0000_0000, 1'b1, "rd_0c"};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,        32'h0000_0000, 1'b0, "rd_wdata"};
        vecs[6]  = '{1'b1, 8'h10, 32'h0005_0002, 32'h0000_0000, 1'b0, "wr_thresh"};
        vecs[7]  = '{1'b0, 8'h10, 32'h0,        32'h0005_0002, 1'b0, "thresh_rb"};
        vecs[8]  = '{1'b1, 8'h10, 32'h0007_0001, 32'h0000_0000, 1'b0, "thresh_restore"};
        vecs[9]  = '{1'b1, 8'h08, 32'h0000_0055, 32'h0000_0000, 1'b0, "wdata_en0"};
        vecs[10] = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "wr_status"};
        vecs[11] = '{1'b0, 8'h04, 32'h0,        32'h0000_0011, 1'b0, "status_ro"};
        vecs[12] = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "wr_irqen"};
        vecs[13] = '{1'b0, 8'h14, 32'h0,        32'h0000_0007, 1'b0, "irqen_rb"};
        vecs[14] = '{1'b1, 8'h14, 32'h0,        32'h0000_0000, 1'b0, "irqen_clr"};
        vecs[15] = '{1'b1, 8'h00, 32'h0000_0006, 32'h0000_0000, 1'b0, "ctrl_w1"};
        vecs[16] = '{1'b0, 8'h00, 32'h0,        32'h0000_0000, 1'b0, "ctrl_w1_rb"};
        vecs[17] = '{1'b1, 8'h20, 32'h1234_5678, 32'h0000_0000, 1'b1, "wr_20"};
        vecs[18] = '{1'b0, 8'hFF, 32'h0,        32'h0000_0000, 1'b1, "rd_ff"};
        vecs[19] = '{1'b1, 8'h0C, 32'h0,        32'h0000_0000, 1'b1, "wr_0c"};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'h0; m_ready = 1'b0;
        #12;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("pready", 32'(PREADY), 32'd1);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Register map table
        for (int i = 0; i < NVEC; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
        end
        check_state("table");

        // Basic push then drain in order
        apb(1'b1, 8'h00, 32'h1, 1'b0, rd, err);
        apb(1'b1, 8'h08, 32'hA1, 1'b0, rd, err);
        apb(1'b1, 8'h08, 32'hA2, 1'b0, rd, err);
        apb(1'b1, 8'h08, 32'hA3, 1'b0, rd, err);
        check("three_level", 32'(level_out), 32'd3);
        check("three_head", 32'(m_data), 32'hA1);
        drain(3);
        check_state("drained");

        // Fill to full, overflow, then clear ovf
        for (int i = 0; i < DEPTH; i++) apb(1'b1, 8'h08, 32'h10 + 32'(i), 1'b0, rd, err);
        check("full_after_8", 32'(full_out), 32'd1);
        apb(1'b1, 8'h08, 32'h99, 1'b0, rd, err);
        check_state("ovf");
        apb(1'b0, 8'h04, 32'h0, 1'b0, rd, err);
        check("status_ovf", rd, 32'h0008_000E);
        apb(1'b1, 8'h00, 32'h5, 1'b0, rd, err);
        apb(1'b0, 8'h04, 32'h0, 1'b0, rd, err);
        check("status_clr_ovf", rd, 32'h0008_000A);

        // Full FIFO: push and pop in the same cycle
        apb(1'b1, 8'h08, 32'h77, 1'b1, rd, err);
        check("simul_level", 32'(level_out), 32'd7);
        apb(1'b0, 8'h04, 32'h0, 1'b0, rd, err);
        check("status_simul", rd, 32'h0007_000C);
        drain(7);
        check_state("simul_drained");
        apb(1'b1, 8'h00, 32'h5, 1'b0, rd, err);

        // Almost-full interrupt timing
        apb(1'b1, 8'h10, 32'h0004_0001, 1'b0, rd, err);
        apb(1'b1, 8'h14, 32'h2, 1'b0, rd, err);
        for (int i = 0; i < 4; i++) apb(1'b1, 8'h08, 32'h21 + 32'(i), 1'b0, rd, err);
        check("af_level", 32'(level_out), 32'd4);
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge PCLK); #1;
        check("irq_set", 32'(irq), 32'd1);
        drain(1);
        check("irq_hold", 32'(irq), 32'd1);
        @(negedge PCLK); #1;
        check("irq_clear", 32'(irq), 32'd0);
        apb(1'b1, 8'h14, 32'h0, 1'b0, rd, err);
        apb(1'b1, 8'h08, 32'h25, 1'b0, rd, err);
        apb(1'b1, 8'h08, 32'h26, 1'b0, rd, err);
        check_state("five");

        // Flush with a concurrent pop request
        apb(1'b1, 8'h00, 32'h3, 1'b1, rd, err);
        check_state("flush");
        apb(1'b0, 8'h00, 32'h0, 1'b0, rd, err);
        check("flush_en_kept", rd, 32'h1);
        apb(1'b1, 8'h08, 32'hB1, 1'b0, rd, err);
        check_state("post_flush");

        // Almost-empty interrupt, then asynchronous reset mid-stream
        apb(1'b1, 8'h14, 32'h4, 1'b0, rd, err);
        @(negedge PCLK);
        @(negedge PCLK); #1;
        check("ae_irq", 32'(irq), 32'd1);
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h0C;
        #1;
        check("slverr_0c", 32'(PSLVERR), 32'd1);
        check("prdata_0c", PRDATA, 32'h0);
        PRESET = 1'b1;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_empty", 32'(empty_out), 32'd1);
        check("arst_level", 32'(level_out), 32'd0);
        check("arst_pslverr", 32'(PSLVERR), 32'd0);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
        sb.delete();
        en_m = 1'b0;
        apb(1'b0, 8'h10, 32'h0, 1'b0, rd, err);
        check("arst_thresh", rd, 32'h0007_0001);
        apb(1'b0, 8'h00, 32'h0, 1'b0, rd, err);
        check("arst_ctrl", rd, 32'h0);
        apb(1'b0, 8'h14, 32'h0, 1'b0, rd, err);
        check("arst_irqen", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
